ipm2t_hssthp_txlane_rst_fsm_v1_0: RTL

IPM2T_HSSTHP_TXLANE_RST_FSM_V1_0 -- requirements
Module: ipm2t_hssthp_txlane_rst_fsm_v1_0

---
 rtl/ipm2t_hssthp_rst_pkg.sv | 43 ++++
 rtl/ipm2t_hssthp_rst_sync_v1_0.sv | 25 ++
 rtl/ipm2t_hssthp_txlane_rst_fsm_v1_0.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ipm2t_hssthp_rst_pkg.sv
// Shared HSSTHP reset package: sequencer state encodings, counter widths and
// timing constants for the LPLL and TX-lane reset FSMs.
package ipm2t_hssthp_rst_pkg;

  localparam int CNTR_W   = 12;
  localparam int CNTR_MAX = (1 << CNTR_W) - 1;

  localparam int PCS_RST_CNT = 32;
  localparam int LOSS_CNT    = 4;
  localparam int LOSS_W      = 3;
  localparam logic [LOSS_W-1:0] LOSS_LIMIT = LOSS_W'(LOSS_CNT);

  // All microsecond-based delays scale with the free-running clock in MHz.
  function automatic int us_to_cycles(input int freq_mhz, input int us);
    return freq_mhz * us;
  endfunction

  function automatic int lpll_pd_cnt(input int freq_mhz);
    return us_to_cycles(freq_mhz, 40);
  endfunction

  function automatic int lpll_rst_cnt(input int freq_mhz);
    return us_to_cycles(freq_mhz, 1);
  endfunction

  function automatic int lane_pu_cnt(input int freq_mhz);
    return us_to_cycles(freq_mhz, 2);
  endfunction

  function automatic int pma_rst_cnt(input int freq_mhz);
    return us_to_cycles(freq_mhz, 2);
  endfunction

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LPLL = 3'd1,
    LANE_PU   = 3'd2,
    PMA_RST   = 3'd3,
    PCS_RST   = 3'd4,
    DONE      = 3'd5
  } txlane_state_e;

endpackage

// File: rtl/ipm2t_hssthp_rst_sync_v1_0.sv
// Two-flop synchroniser for asynchronous status inputs; clears to 0 in reset.
module ipm2t_hssthp_rst_sync_v1_0 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[1];

endmodule

// File: rtl/ipm2t_hssthp_txlane_rst_fsm_v1_0.sv
// TX lane reset sequencer: waits for LPLL, powers the lane up, then releases
// PMA and PCS resets in turn; falls back to WAIT_LPLL on PLL loss.
module ipm2t_hssthp_txlane_rst_fsm_v1_0
  import ipm2t_hssthp_rst_pkg::*;
#(
  parameter int FREE_CLOCK_FREQ = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_lpll_done,
  input  logic pll_lock,
  input  logic i_txlane_rst,
  output logic P_TX_LANE_PD,
  output logic P_TX_PMA_RST,
  output logic P_TX_PCS_RST,
  output logic o_txlane_done
);

  localparam int LANE_PU_CNT = lane_pu_cnt(FREE_CLOCK_FREQ);
  localparam int PMA_RST_CNT = pma_rst_cnt(FREE_CLOCK_FREQ);

  localparam logic [CNTR_W-1:0] LANE_PU_LAST = CNTR_W'(LANE_PU_CNT - 1);
  localparam logic [CNTR_W-1:0] PMA_RST_LAST = CNTR_W'(PMA_RST_CNT - 1);
  localparam logic [CNTR_W-1:0] PCS_RST_LAST = CNTR_W'(PCS_RST_CNT - 1);

  if (LANE_PU_CNT > CNTR_MAX || PMA_RST_CNT > CNTR_MAX ||
      PCS_RST_CNT > CNTR_MAX || LOSS_CNT > CNTR_MAX) begin : g_cntr_range
    $error("txlane reset timing constant exceeds the 12-bit counter range");
  end

  logic lpll_done_s;
  logic lock_s;

  ipm2t_hssthp_rst_sync_v1_0 u_sync_lpll_done (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (i_lpll_done),
    .q     (lpll_done_s)
  );

  ipm2t_hssthp_rst_sync_v1_0 u_sync_pll_lock (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  txlane_state_e     state_q, state_d;
  logic [CNTR_W-1:0] cntr_q, cntr_d;
  logic [LOSS_W-1:0] loss_cnt_q, loss_cnt_d;
  logic              lane_pd_q, lane_pd_d;
  logic              pma_rst_q, pma_rst_d;
  logic              pcs_rst_q, pcs_rst_d;
  logic              done_q, done_d;
  logic              monitor;
  logic              loss;

  // NOTE: every combinational output gets a default first so no path through
  // the case/if tree leaves a variable unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    cntr_d     = '0;
    loss_cnt_d = '0;
    monitor    = state_q inside {LANE_PU, PMA_RST, PCS_RST, DONE};

    if (monitor && !lock_s) begin
      loss_cnt_d = (loss_cnt_q == LOSS_LIMIT) ? loss_cnt_q : loss_cnt_q + 1'b1;
    end
    loss = monitor && (!lpll_done_s || loss_cnt_d == LOSS_LIMIT);

    case (state_q)
      IDLE:      state_d = WAIT_LPLL;
      WAIT_LPLL: if (lpll_done_s && lock_s) state_d = LANE_PU;
      LANE_PU:   if (cntr_q == LANE_PU_LAST) state_d = PMA_RST;
      PMA_RST:   if (cntr_q == PMA_RST_LAST) state_d = PCS_RST;
      PCS_RST:   if (cntr_q == PCS_RST_LAST) state_d = DONE;
      DONE:      state_d = DONE;
      default:   state_d = IDLE;
    endcase

    // Soft reset outranks loss, which outranks normal sequencing.
    if (loss)         state_d = WAIT_LPLL;
    if (i_txlane_rst) state_d = IDLE;

    if (state_d == state_q && state_q inside {LANE_PU, PMA_RST, PCS_RST}) begin
      cntr_d = cntr_q + 1'b1;
    end
    if (!(state_d inside {LANE_PU, PMA_RST, PCS_RST, DONE})) begin
      loss_cnt_d = '0;
    end

    // Outputs are decoded from the next state so they change on the same edge
    // as the transition that causes them.
    lane_pd_d = state_d inside {IDLE, WAIT_LPLL};
    pma_rst_d = !(state_d inside {PCS_RST, DONE});
    pcs_rst_d = (state_d != DONE);
    done_d    = (state_q == DONE) && (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cntr_q     <= '0;
      loss_cnt_q <= '0;
      lane_pd_q  <= 1'b1;
      pma_rst_q  <= 1'b1;
      pcs_rst_q  <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cntr_q     <= cntr_d;
      loss_cnt_q <= loss_cnt_d;
      lane_pd_q  <= lane_pd_d;
      pma_rst_q  <= pma_rst_d;
      pcs_rst_q  <= pcs_rst_d;
      done_q     <= done_d;
    end
  end

  assign P_TX_LANE_PD  = lane_pd_q;
  assign P_TX_PMA_RST  = pma_rst_q;
  assign P_TX_PCS_RST  = pcs_rst_q;
  assign o_txlane_done = done_q;

endmodule
